// File: rtl/cphy_esc_pkg.sv
// Shared definitions for the C-PHY escape-mode receive path:
// entry command codes and the decoder state encoding.
package cphy_esc_pkg;

  localparam logic [7:0] ESC_CMD_LPDT     = 8'hE1;
  localparam logic [7:0] ESC_CMD_ULPS     = 8'h1E;
  localparam logic [7:0] ESC_CMD_RST_TRIG = 8'h62;
  localparam logic [7:0] ESC_CMD_TRIG1    = 8'h5D;
  localparam logic [7:0] ESC_CMD_TRIG2    = 8'h21;
  localparam logic [7:0] ESC_CMD_TRIG3    = 8'hA0;

  typedef enum logic [2:0] {
    ESC_IDLE = 3'd0,
    ESC_CMD  = 3'd1,
    ESC_LPDT = 3'd2,
    ESC_ULPS = 3'd3,
    ESC_WAIT = 3'd4
  } esc_state_t;

endpackage

// File: rtl/esc_shift_reg.sv
// Serial-to-parallel shifter shared by command and LPDT payload capture.
// Direction is selectable per bit (MSB-first for commands, LSB-first for
// payload). The counter wraps after DATA_W bits and raises `full` for the
// cycle following the last bit.
module esc_shift_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              shift,
  input  logic              clear,
  input  logic              msbFirst,
  input  logic              bitIn,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  function automatic logic [DATA_W-1:0] shiftIn(input logic [DATA_W-1:0] cur,
                                                input logic b,
                                                input logic msb);
    if (msb) return {cur[DATA_W-2:0], b};
    else     return {b, cur[DATA_W-1:1]};
  endfunction

  // Bit counter and full flag; start loads the first bit of a new field.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      full  <= 1'b0;
    end else if (start) begin
      count <= CNT_W'(1);
      full  <= 1'b0;
    end else if (shift) begin
      if (count == CNT_W'(DATA_W - 1)) begin
        count <= '0;
        full  <= 1'b1;
      end else begin
        count <= count + 1'b1;
        full  <= 1'b0;
      end
    end
  end

  // Data register carries no reset; only bits counted by `count` are meaningful.
  always_ff @(posedge clk) begin
    if (start || shift) data <= shiftIn(data, bitIn, msbFirst);
  end

endmodule

// File: rtl/escape_rx_decoder.sv
// Escape-mode receive decoder: captures the entry command, then delivers
// LPDT bytes, the ULPS state and trigger events to the PPI.
// Optional feature macro: ESC_TRIGGER_EN (trigger command decoding).
// The single shared shifter assumes CMD_W == DATA_W.
module escape_rx_decoder
  import cphy_esc_pkg::*;
#(
  parameter int CMD_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              RxClkEsc,
  input  logic              Rst,
  input  logic              En,
  input  logic              A,
  output logic [DATA_W-1:0] RxDataEsc,
  output logic              RxValidEsc,
  output logic              RxLpdtEsc,
  output logic              RxUlpsEsc,
  output logic [3:0]        RxTriggerEsc,
  output logic              ErrEsc,
  output logic              ErrSyncEsc
);

  localparam int CNT_W = $clog2(DATA_W);

  esc_state_t          state, nextState;
  logic                shStart, shShift, shClear, shMsbFirst, shFull;
  logic [DATA_W-1:0]   shData;
  logic [CNT_W-1:0]    shCount;
  logic [CMD_W-1:0]    cmd;
  logic                cmdErr;
`ifdef ESC_TRIGGER_EN
  logic [3:0]          cmdTrig;
  logic [3:0]          trigReg;
`endif

  assign cmd = shData[CMD_W-1:0];

  esc_shift_reg #(.DATA_W(DATA_W)) shifter (
    .clk      (RxClkEsc),
    .rst      (Rst),
    .start    (shStart),
    .shift    (shShift),
    .clear    (shClear),
    .msbFirst (shMsbFirst),
    .bitIn    (A),
    .data     (shData),
    .count    (shCount),
    .full     (shFull)
  );

  // Next-state, shifter control and command decode; En=0 always wins.
  always_comb begin
    nextState  = state;
    shStart    = 1'b0;
    shShift    = 1'b0;
    shClear    = 1'b0;
    shMsbFirst = 1'b1;
    cmdErr     = 1'b0;
`ifdef ESC_TRIGGER_EN
    cmdTrig    = 4'b0000;
`endif
    case (state)
      ESC_IDLE: begin
        if (En) begin
          nextState = ESC_CMD;
          shStart   = 1'b1;
        end
      end
      ESC_CMD: begin
        if (!En) begin
          nextState = ESC_IDLE;
          shClear   = 1'b1;
        end else if (shFull) begin
          // Decode edge; an LPDT entry also captures the first payload bit.
          shClear   = 1'b1;
          nextState = ESC_WAIT;
          case (cmd)
            ESC_CMD_LPDT: begin
              nextState  = ESC_LPDT;
              shClear    = 1'b0;
              shStart    = 1'b1;
              shMsbFirst = 1'b0;
            end
            ESC_CMD_ULPS:     nextState = ESC_ULPS;
`ifdef ESC_TRIGGER_EN
            ESC_CMD_RST_TRIG: cmdTrig = 4'b0001;
            ESC_CMD_TRIG1:    cmdTrig = 4'b0010;
            ESC_CMD_TRIG2:    cmdTrig = 4'b0100;
            ESC_CMD_TRIG3:    cmdTrig = 4'b1000;
`endif
            default:          cmdErr = 1'b1;
          endcase
        end else begin
          shShift = 1'b1;
        end
      end
      ESC_LPDT: begin
        shMsbFirst = 1'b0;
        if (!En) begin
          nextState = ESC_IDLE;
          shClear   = 1'b1;
        end else begin
          shShift = 1'b1;
        end
      end
      ESC_ULPS, ESC_WAIT: begin
        if (!En) begin
          nextState = ESC_IDLE;
          shClear   = 1'b1;
        end
      end
      default: begin
        nextState = ESC_IDLE;
        shClear   = 1'b1;
      end
    endcase
  end

  // State and registered PPI outputs; pulses default low every cycle.
  always_ff @(posedge RxClkEsc) begin
    if (Rst) begin
      state      <= ESC_IDLE;
      RxDataEsc  <= '0;
      RxValidEsc <= 1'b0;
      RxLpdtEsc  <= 1'b0;
      RxUlpsEsc  <= 1'b0;
      ErrEsc     <= 1'b0;
      ErrSyncEsc <= 1'b0;
    end else begin
      state      <= nextState;
      RxLpdtEsc  <= (nextState == ESC_LPDT);
      RxUlpsEsc  <= (nextState == ESC_ULPS);
      ErrEsc     <= cmdErr;
      ErrSyncEsc <= (state == ESC_LPDT) && !En && (shCount != '0);
      RxValidEsc <= 1'b0;
      // A completed byte is delivered even if En drops on this edge.
      if (state == ESC_LPDT && shFull) begin
        RxDataEsc  <= shData;
        RxValidEsc <= 1'b1;
      end
    end
  end

`ifdef ESC_TRIGGER_EN
  // One-cycle trigger pulse registered from the decode edge.
  always_ff @(posedge RxClkEsc) begin
    if (Rst) trigReg <= 4'b0000;
    else     trigReg <= cmdTrig;
  end
  assign RxTriggerEsc = trigReg;
`else
  assign RxTriggerEsc = 4'b0000;
`endif

endmodule

// File: tb/tb_escape_rx_decoder.sv
// Scoreboard bench for escape_rx_decoder: expected output events are queued
// as stimulus is driven and matched by a monitor as the DUT emits them.
module tb_escape_rx_decoder;
  import cphy_esc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       a   = 1'b0;
  logic [7:0] rxData;
  logic       rxValid, rxLpdt, rxUlps, err, errSync;
  logic [3:0] rxTrig;

  int         nChecks = 0;
  int         nPass   = 0;
  int         cyc     = 0;
  logic [15:0] expQ[$];
  int         validCyc[$];

  escape_rx_decoder #(.CMD_W(8), .DATA_W(8)) dut (
    .RxClkEsc     (clk),
    .Rst          (rst),
    .En           (en),
    .A            (a),
    .RxDataEsc    (rxData),
    .RxValidEsc   (rxValid),
    .RxLpdtEsc    (rxLpdt),
    .RxUlpsEsc    (rxUlps),
    .RxTriggerEsc (rxTrig),
    .ErrEsc       (err),
    .ErrSyncEsc   (errSync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Event encoding: {kind, trigger, data}; kind 1=byte 2=trigger 3=err 4=errSync.
  task automatic popCheck(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    exp = 16'h0000;
    if (expQ.size() > 0) exp = expQ.pop_front();
    checkEq(tag, 32'(obs), 32'(exp));
  endtask

  // Monitor: sample outputs 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (rxValid) begin
      validCyc.push_back(cyc);
      popCheck("byte", {4'd1, 4'd0, rxData});
    end
    if (rxTrig != 4'b0000) popCheck("trigger", {4'd2, rxTrig, 8'd0});
    if (err)               popCheck("errEsc", {4'd3, 12'd0});
    if (errSync)           popCheck("errSync", {4'd4, 12'd0});
  end

  task automatic driveRst(input logic r, input logic e, input logic b);
    @(negedge clk);
    rst = r;
    en  = e;
    a   = b;
  endtask

  task automatic drive(input logic e, input logic b);
    driveRst(1'b0, e, b);
  endtask

  task automatic sendCmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) drive(1'b1, c[i]);
  endtask

  task automatic sendByte(input logic [7:0] d);
    expQ.push_back({4'd1, 4'd0, d});
    for (int i = 0; i < 8; i++) drive(1'b1, d[i]);
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, "_idle"}, 32'(dut.state), 32'(ESC_IDLE));
    checkEq({tag, "_lpdt"}, 32'(rxLpdt), 32'd0);
    checkEq({tag, "_ulps"}, 32'(rxUlps), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, "_data"}, 32'(rxData), 32'd0);
    checkEq({tag, "_valid"}, 32'(rxValid), 32'd0);
    checkEq({tag, "_trig"}, 32'(rxTrig), 32'd0);
    checkEq({tag, "_err"}, 32'(err), 32'd0);
    checkEq({tag, "_errSync"}, 32'(errSync), 32'd0);
    checkIdle(tag);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) driveRst(1'b1, 1'b0, 1'b0);
    checkAllZero("reset");
    drive(1'b0, 1'b0);

    // LPDT single byte 0xA5, then clean exit on the delivery edge
    sendCmd(ESC_CMD_LPDT);
    sendByte(8'hA5);
    drive(1'b0, 1'b0);
    checkEq("lpdt_flag", 32'(rxLpdt), 32'd1);
    drive(1'b0, 1'b0);
    checkIdle("lpdt_exit");
    checkEq("lpdt_data_hold", 32'(rxData), 32'hA5);

    // Back-to-back bytes with no gap
    validCyc.delete();
    sendCmd(ESC_CMD_LPDT);
    sendByte(8'h3C);
    sendByte(8'hFF);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checkIdle("b2b_exit");
    checkEq("b2b_count", 32'(validCyc.size()), 32'd2);
    if (validCyc.size() == 2)
      checkEq("b2b_spacing", 32'(validCyc[1] - validCyc[0]), 32'd8);

    // ULPS held through 10 edges with arbitrary line activity
    sendCmd(ESC_CMD_ULPS);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)));
      if (i > 0) checkEq("ulps_flag", 32'(rxUlps), 32'd1);
    end
    checkEq("ulps_nolpdt", 32'(rxLpdt), 32'd0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checkIdle("ulps_exit");

    // Trigger 1 command
`ifdef ESC_TRIGGER_EN
    expQ.push_back({4'd2, 4'b0010, 8'd0});
`else
    expQ.push_back({4'd3, 12'd0});
`endif
    sendCmd(ESC_CMD_TRIG1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    checkEq("trig_nolpdt", 32'(rxLpdt), 32'd0);
    checkEq("trig_noulps", 32'(rxUlps), 32'd0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checkIdle("trig_exit");

    // Unknown command 0x00
    expQ.push_back({4'd3, 12'd0});
    sendCmd(8'h00);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    checkEq("unk_nolpdt", 32'(rxLpdt), 32'd0);
    checkEq("unk_noulps", 32'(rxUlps), 32'd0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checkIdle("unk_exit");

    // Partial byte: 3 payload bits then exit
    expQ.push_back({4'd4, 12'd0});
    sendCmd(ESC_CMD_LPDT);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checkEq("partial_lpdt", 32'(rxLpdt), 32'd1);
    drive(1'b0, 1'b0);
    checkIdle("partial_exit");

    // Reset during the 5th payload bit, then a normal entry
    sendCmd(ESC_CMD_LPDT);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1);
    driveRst(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checkAllZero("midrst");
    drive(1'b0, 1'b0);
    sendCmd(ESC_CMD_LPDT);
    sendByte(8'h5A);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checkIdle("post_rst");
    checkEq("post_rst_data", 32'(rxData), 32'h5A);

    repeat (3) drive(1'b0, 1'b0);
    checkEq("scoreboard_drain", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
